// File: rtl/dmem_responder.sv
// -----------------------------------------------------------------------------
// dmem_responder
//
// Data-memory responder behind the pipeline memory stage. Takes one load/store
// at a time, waits LATENCY cycles, performs the word access on an internal RAM
// and returns a one-cycle response carrying read data and an error flag.
//
// Parameters:
//   ADDR_WIDTH  word-address bits; RAM holds 2**ADDR_WIDTH 32-bit words
//   LATENCY     wait cycles between acceptance and access (0..15)
//
// Ports:
//   clk         rising-edge clock
//   reset       asynchronous, active-low reset
//   req_valid   request present this cycle
//   req_write   1 = store, 0 = load
//   req_addr    byte address
//   req_wdata   store data
//   req_ready   a request can be accepted this cycle
//   resp_valid  one-cycle pulse when the access completes
//   resp_rdata  load data (0 for stores and errors)
//   resp_err    misaligned or out-of-range request
//   stall       pipeline must hold: an accepted access has no response yet
// -----------------------------------------------------------------------------
module dmem_responder #(
  parameter int ADDR_WIDTH = 10,
  parameter int LATENCY    = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        req_ready,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        stall
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  localparam bit        ZERO_LAT = (LATENCY == 0);
  localparam logic [3:0] LAT_LOAD = ZERO_LAT ? 4'd0 : 4'(LATENCY - 1);

  // Misaligned or beyond the RAM's byte range.
  function automatic logic addr_err(input logic [31:0] addr);
    logic [31:0] hi;
    hi = addr >> (ADDR_WIDTH + 2);
    return (addr[1:0] != 2'b00) || (hi != 32'd0);
  endfunction

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        write_q, write_d;
  logic        resp_valid_q, resp_valid_d;
  logic [31:0] resp_rdata_q, resp_rdata_d;
  logic        resp_err_q, resp_err_d;

  logic [31:0] mem_q [0:(2**ADDR_WIDTH)-1];

  logic                  ready_s;
  logic                  hs_s;
  logic                  enter_resp_s;
  logic [31:0]           acc_addr_s;
  logic [31:0]           acc_wdata_s;
  logic                  acc_write_s;
  logic                  acc_err_s;
  logic [ADDR_WIDTH-1:0] acc_idx_s;
  logic                  mem_we_s;

  assign ready_s = (state_q != ST_WAIT);
  assign hs_s    = req_valid & ready_s;

  // With zero latency the access happens on the accepting edge itself, so the
  // live request fields are used instead of the not-yet-latched copies.
  assign acc_addr_s   = ZERO_LAT ? req_addr  : addr_q;
  assign acc_wdata_s  = ZERO_LAT ? req_wdata : wdata_q;
  assign acc_write_s  = ZERO_LAT ? req_write : write_q;
  assign enter_resp_s = ZERO_LAT ? hs_s : ((state_q == ST_WAIT) && (cnt_q == 4'd0));
  assign acc_idx_s    = acc_addr_s[ADDR_WIDTH+1:2];
  assign acc_err_s    = addr_err(acc_addr_s);

  // Gating with reset keeps a zero-latency handshake seen during reset from
  // writing the RAM, whose port has no reset of its own.
  assign mem_we_s = enter_resp_s & acc_write_s & ~acc_err_s & reset;

  // Next-state, counter, request latch and response computation.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    write_d      = write_q;
    resp_valid_d = enter_resp_s;
    resp_err_d   = enter_resp_s & acc_err_s;
    resp_rdata_d = 32'd0;

    if (enter_resp_s && !acc_write_s && !acc_err_s) begin
      resp_rdata_d = mem_q[acc_idx_s];
    end else begin
      resp_rdata_d = 32'd0;
    end

    if (hs_s) begin
      addr_d  = req_addr;
      wdata_d = req_wdata;
      write_d = req_write;
    end else begin
      addr_d  = addr_q;
      wdata_d = wdata_q;
      write_d = write_q;
    end

    case (state_q)
      ST_IDLE, ST_RESP: begin
        if (hs_s) begin
          if (ZERO_LAT) begin
            state_d = ST_RESP;
            cnt_d   = 4'd0;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = LAT_LOAD;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // Control and response registers; reset drops any pending access.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      cnt_q        <= 4'd0;
      addr_q       <= 32'd0;
      wdata_q      <= 32'd0;
      write_q      <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= 32'd0;
      resp_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      write_q      <= write_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
    end
  end

  // RAM write port; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      mem_q[acc_idx_s] <= acc_wdata_s;
    end
  end

  assign req_ready  = ready_s;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;
  assign stall      = (state_q == ST_WAIT) | (hs_s & !ZERO_LAT);

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Data-memory responder sitting on the far side of the pipeline's memory stage. Accepts one load/store request at a time from the core (address, write data, write strobe), models a configurable number of wait states, performs the word access on an internal RAM, and returns a single-cycle response with read data and an error flag. A `stall` output tells the hazard logic to freeze the pipeline while an access is outstanding.

## Interface
Parameters:
- `ADDR_WIDTH`, 10: word-address bits; RAM depth is 2**ADDR_WIDTH 32-bit words.
- `LATENCY`, 2: wait cycles between acceptance and access, legal range 0..15.

Ports:
- `clk`  in  1  sole clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `req_valid`  in  1  request present this cycle.
- `req_write`  in  1  1 = store, 0 = load.
- `req_addr`  in  32  byte address (ALU result of the memory stage).
- `req_wdata`  in  32  store data.
- `req_ready`  out  1  responder can accept a request this cycle.
- `resp_valid`  out  1  one-cycle pulse: access complete.
- `resp_rdata`  out  32  load data. 0 for stores and errors.
- `resp_err`  out  1  request was misaligned or out of range.
- `stall`  out  1  pipeline must hold; an accepted access has no response yet.

## Operation
- States: IDLE, WAIT, RESP.
- `req_ready` = 1 in IDLE and RESP, 0 in WAIT. Handshake = `req_valid & req_ready`; request fields are latched on that edge.
- On handshake: if LATENCY = 0, go to RESP. Otherwise load `cnt` = LATENCY-1 and go to WAIT.
- WAIT: `cnt` decrements each cycle. When `cnt` = 0, go to RESP.
- The access is performed on the edge that enters RESP.
  - Store: RAM[addr[ADDR_WIDTH+1:2]] <= wdata.
  - Load: `resp_rdata` <= RAM word.
- RESP: `resp_valid` = 1 for exactly that cycle.
  - A handshake in RESP starts the next request with the same rules.
  - Otherwise return to IDLE.
- `req_valid` in WAIT is ignored. The core must hold it until `req_ready`.
- Error check uses the latched address:
  - misaligned if addr[1:0] != 0;
  - out of range if addr[31:ADDR_WIDTH+2] != 0.
- On error: no RAM write, `resp_rdata` = 0, `resp_err` = 1 in the RESP cycle. `resp_err` is 0 in every other cycle.
- `stall` (combinational) = (state == WAIT) | (`req_valid` & `req_ready` & LATENCY != 0).
- RAM contents are not reset. Reads of never-written words are undefined; the bench initialises memory through stores.

## Timing
- Reset (async assert, sync release) values: state = IDLE, `cnt` = 0, `resp_valid` = 0, `resp_rdata` = 0, `resp_err` = 0. So `req_ready` = 1 and `stall` = 0 out of reset.
- Request accepted at edge of cycle T: `resp_valid` is high in cycle T+LATENCY+1.
- A store is visible to any load accepted in or after its RESP cycle.
- Throughput: one access per LATENCY+1 cycles. With LATENCY = 0 that is one per cycle, back-to-back, with no idle bubble.
- Reset asserted in WAIT: the pending access is dropped. No RAM write occurs and no `resp_valid` is produced after release.
- Reset asserted in RESP: `resp_valid` drops immediately. A store already committed on the entry edge stays in RAM.
- `cnt` width: 4 bits, which is enough for LATENCY ≤ 15.

## Test plan
- LATENCY = 2: store 0xDEADBEEF to 0x00000010 at T. `resp_valid` = 1, `resp_err` = 0 at T+3. Then load 0x10: `resp_rdata` = 0xDEADBEEF three cycles after acceptance. `stall` is high for cycles T..T+2.
- Misaligned store to 0x00000012 with wdata 0x12345678: `resp_err` = 1, `resp_rdata` = 0. A later load of 0x10 still returns 0xDEADBEEF.
- ADDR_WIDTH = 10: load 0x00001000 (word 1024) -> `resp_err` = 1, `resp_rdata` = 0. Load 0x00000FFC -> `resp_err` = 0.
- LATENCY = 0: four consecutive stores to 0x0, 0x4, 0x8, 0xC (data 1..4), then four loads. `req_ready` stays 1 and `resp_valid` is high every cycle. Loads return 1, 2, 3, 4 in order. `stall` stays 0.
- LATENCY = 3: store 0xAAAA5555 to 0x20, then pulse `reset` low during the second WAIT cycle. No `resp_valid` follows, and outputs match reset values.
  - Prior to the aborted store, 0x20 holds 0x11111111 (written as setup).
  - Loading 0x20 afterwards returns 0x11111111.
- LATENCY = 2: `req_valid` held high with a new address during WAIT. `req_ready` = 0 during WAIT and the new request is not latched. It is accepted in the RESP cycle, and its response arrives three cycles later.
